// File: rtl/led_arbiter_pkg.sv
// rtl/led_arbiter_pkg.sv - shared types, default constants and helpers for the LED bank arbiter
package led_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   localparam int NREQ_DEF  = 4;
   localparam int W_DEF     = 8;
   localparam int DWELL_DEF = 1024;

   // Round-robin successor of idx among n requesters.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/led_arbiter_if.sv
// rtl/led_arbiter_if.sv - request/data/grant bundle between requesters and the LED bank arbiter
interface led_arbiter_if #(
   parameter int NREQ = led_arb_pkg::NREQ_DEF,
   parameter int W    = led_arb_pkg::W_DEF
) ();

   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] data;
   logic [NREQ-1:0]   grant;
   logic [W-1:0]      d_out;
   logic              busy;

   modport master (
      output req,
      output data,
      input  grant,
      input  d_out,
      input  busy
   );

   modport slave (
      input  req,
      input  data,
      output grant,
      output d_out,
      output busy
   );

endinterface

// File: rtl/led_arbiter_rr_pick.sv
// rtl/led_arbiter_rr_pick.sv - combinational round-robin picker with exclude mask
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   start,
   input  logic [NREQ-1:0] excl,
   output logic [NREQ-1:0] winner,
   output logic            valid
);

   int idx;

   // First eligible requester at or after start, wrapping modulo NREQ.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(start) + k) % NREQ;
         if (!valid && req[IW'(idx)] && !excl[IW'(idx)]) begin
            winner[IW'(idx)] = 1'b1;
            valid            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - round-robin LED/GPIO bank arbiter with minimum-dwell pre-emption
module led_arbiter
   import led_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int W     = W_DEF,
   parameter int DWELL = DWELL_DEF
) (
   input  logic          clk,
   input  logic          rst,
   led_arbiter_if.slave  bus
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(DWELL);
   localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL - 1);
   localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [W-1:0]    d_out_q, d_out_d;
   logic            busy_q, busy_d;
   logic [CW-1:0]   dwell_q, dwell_d;
   logic [IW-1:0]   last_q, last_d;

   logic [IW-1:0]   start_idx;
   logic [NREQ-1:0] excl_mask;
   logic [NREQ-1:0] pick_oh;
   logic            pick_valid;
   logic [IW-1:0]   pick_idx;
   logic            owner_req;

   // last always equals the owner while OWNED, so the search naturally begins after the owner.
   assign start_idx = IW'(rr_next(int'(last_q), NREQ));
   assign excl_mask = (state_q == OWNED) ? grant_q : '0;
   assign owner_req = |(bus.req & grant_q);

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req    (bus.req),
      .start  (start_idx),
      .excl   (excl_mask),
      .winner (pick_oh),
      .valid  (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_oh[i]) begin
            pick_idx = IW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      dwell_d = dwell_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = OWNED;
               grant_d = pick_oh;
               dwell_d = '0;
               last_d  = pick_idx;
            end
         end
         OWNED: begin
            if (!owner_req || (dwell_q == DWELL_MAX)) begin
               if (pick_valid) begin
                  grant_d = pick_oh;
                  dwell_d = '0;
                  last_d  = pick_idx;
               end else if (!owner_req) begin
                  state_d = IDLE;
                  grant_d = '0;
                  dwell_d = '0;
               end
               // Otherwise the owner keeps the bank and dwell stays saturated.
            end else begin
               dwell_d = dwell_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            dwell_d = '0;
         end
      endcase
   end

   // Output bank follows the next owner's pattern as sampled on this edge.
   always_comb begin
      d_out_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_d[i]) begin
            d_out_d = bus.data[i*W +: W];
         end
      end
      busy_d = |grant_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         d_out_q <= '0;
         busy_q  <= 1'b0;
         dwell_q <= '0;
         last_q  <= LAST_RST;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         d_out_q <= d_out_d;
         busy_q  <= busy_d;
         dwell_q <= dwell_d;
         last_q  <= last_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.d_out = d_out_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - self-checking bench for led_arbiter against a behavioural model
module tb_led_arbiter;

   localparam int NREQ  = 4;
   localparam int W     = 8;
   localparam int DWELL = 4;

   logic clk;
   logic rst;

   int tests_run;
   int tests_failed;

   int          m_owner;
   int          m_dwell;
   int          m_last;
   logic [7:0]  m_dout;
   logic [3:0]  m_req_prev;

   led_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   led_arbiter #(
      .NREQ  (NREQ),
      .W     (W),
      .DWELL (DWELL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_search(input logic [3:0] rq, input int from, input int excl);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (from + 1 + k) % NREQ;
         if (rq[i] && i != excl) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] m_grant();
      return (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
   endfunction

   task automatic model_step(input logic r, input logic [3:0] rq, input logic [31:0] dt);
      int w;
      if (r) begin
         m_owner = -1;
         m_dwell = 0;
         m_last  = NREQ - 1;
      end else if (m_owner < 0) begin
         w = rr_search(rq, m_last, -1);
         if (w >= 0) begin
            m_owner = w;
            m_dwell = 0;
            m_last  = w;
         end
      end else begin
         w = rr_search(rq, m_last, m_owner);
         if (!rq[m_owner]) begin
            m_owner = w;
            m_dwell = 0;
            if (w >= 0) m_last = w;
         end else if (m_dwell < DWELL - 1) begin
            m_dwell++;
         end else if (w >= 0) begin
            m_owner = w;
            m_dwell = 0;
            m_last  = w;
         end
      end
      m_dout = (m_owner >= 0) ? dt[m_owner*8 +: 8] : 8'h00;
      m_req_prev = rq;
   endtask

   task automatic tick(input logic r, input logic [3:0] rq, input logic [31:0] dt);
      rst      = r;
      bus.req  = rq;
      bus.data = dt;
      model_step(r, rq, dt);
      @(posedge clk);
      #1;
      check("grant", 32'(bus.grant), m_grant());
      check("d_out", 32'(bus.d_out), 32'(m_dout));
      check("busy",  32'(bus.busy),  32'(m_owner >= 0));
      check("onehot", 32'($onehot0(bus.grant)), 32'd1);
      check("grant_req", 32'(bus.grant & ~m_req_prev), 32'd0);
   endtask

   initial begin
      logic [3:0]  rq;
      logic [31:0] dt;
      logic [7:0]  d3_first;
      tests_run    = 0;
      tests_failed = 0;
      m_owner      = -1;
      m_dwell      = 0;
      m_last       = NREQ - 1;
      m_dout       = 8'h00;
      m_req_prev   = 4'b0000;
      rst          = 1'b1;
      bus.req      = '0;
      bus.data     = '0;

      tick(1'b1, 4'b0000, 32'h0);
      tick(1'b1, 4'b0000, 32'h0);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_dout",  32'(bus.d_out), 32'd0);
      check("rst_busy",  32'(bus.busy),  32'd0);

      tick(1'b0, 4'b0001, 32'h3C5A_77A5);
      check("first_grant", 32'(bus.grant), 32'h1);
      check("first_dout",  32'(bus.d_out), 32'hA5);
      check("first_busy",  32'(bus.busy),  32'h1);

      // Two requesters alternate every DWELL cycles.
      tick(1'b1, 4'b0000, 32'h0);
      for (int c = 0; c < 16; c++) begin
         tick(1'b0, 4'b0110, 32'h4433_2211);
         check("alt_grant", 32'(bus.grant), ((c / 4) % 2 == 0) ? 32'h2 : 32'h4);
      end

      // Owner release hands over with no idle bubble.
      tick(1'b1, 4'b0000, 32'h0);
      tick(1'b0, 4'b0001, 32'h0000_BB00 | 32'h11);
      tick(1'b0, 4'b0100, 32'h00CC_0000);
      check("release_grant", 32'(bus.grant), 32'h4);
      check("release_dout",  32'(bus.d_out), 32'hCC);

      // Single requester saturates dwell and keeps a steady bank.
      tick(1'b1, 4'b0000, 32'h0);
      d3_first = 8'h96;
      for (int c = 0; c < 20; c++) begin
         tick(1'b0, 4'b1000, {d3_first, 24'($urandom)});
         check("solo_grant", 32'(bus.grant), 32'h8);
         check("solo_dout",  32'(bus.d_out), 32'(d3_first));
      end

      // Reset mid-ownership of index 2, then restart from index 0.
      tick(1'b1, 4'b0000, 32'h0);
      tick(1'b0, 4'b0100, 32'h0055_0000);
      check("own2_grant", 32'(bus.grant), 32'h4);
      tick(1'b1, 4'b1111, 32'h0055_0000);
      check("midrst_grant", 32'(bus.grant), 32'h0);
      check("midrst_dout",  32'(bus.d_out), 32'h0);
      check("midrst_busy",  32'(bus.busy),  32'h0);
      tick(1'b0, 4'b1111, 32'h4433_2211);
      check("restart_grant", 32'(bus.grant), 32'h1);
      check("restart_dout",  32'(bus.d_out), 32'h11);

      // Randomized traffic with sticky requests and rare resets.
      rq = 4'b0000;
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
         dt = $urandom;
         tick(($urandom_range(0, 299) == 0), rq, dt);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the LED/GPIO output bank; legal range 2..8.
REQ-002 Parameter W, default 8: LED output bank width in bits.
REQ-003 Parameter DWELL, default 1024: minimum granted cycles before the owner can be pre-empted; legal range 2..4095.
REQ-004 clk  input  1: single clock, the on-chip high-frequency oscillator output; all logic on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 req  input  NREQ: per-requester level request; bit i held high while requester i wants the bank.
REQ-007 data  input  NREQ*W: requester i drive pattern on bits [i*W +: W].
REQ-008 grant  output  NREQ: registered one-hot ownership; all zero when idle.
REQ-009 d_out  output  W: registered LED bank drive.
REQ-010 busy  output  1: registered; high whenever grant is non-zero.

Function
REQ-011 Two states: IDLE (no owner) and OWNED (exactly one grant bit set).
REQ-012 Round-robin order: search starts at index last+1 and wraps modulo NREQ; last is the most recently granted index; last resets to NREQ-1, so index 0 wins first.
REQ-013 IDLE: if any req bit is high at edge n, the round-robin winner's grant bit is high from cycle n+1 and the state moves to OWNED; otherwise stay IDLE.
REQ-014 OWNED, owner req high, dwell count < DWELL-1: keep grant; dwell count increments by 1.
REQ-015 OWNED, owner req low at edge n: release with no bubble; from cycle n+1 grant goes to the round-robin winner among the other pending requesters, or to IDLE if none.
REQ-016 OWNED, owner req high, dwell count == DWELL-1, another req pending: pre-empt; from the next cycle grant goes to the round-robin winner, excluding the current owner.
REQ-017 OWNED, dwell count == DWELL-1, no other req pending: keep grant; dwell count saturates at DWELL-1.
REQ-018 Dwell count clears to 0 on every grant change, including IDLE to OWNED.
REQ-019 Each ownership change updates last to the new owner index.
REQ-020 d_out at cycle n+1 = data slice of the index granted at n+1, sampled at edge n; all zero in cycles where grant is zero.
REQ-021 Latency from req to grant and to d_out: 1 cycle; no combinational path from any input to any output.
REQ-022 Simultaneous release and new requests: the released owner is excluded from the search in that cycle.
REQ-023 grant is never multi-hot; grant is never set for a requester whose req was low at the deciding edge.
REQ-024 Dwell counter width: clog2(DWELL); no wrap-around.

Reset
REQ-025 rst high at an edge forces: state IDLE, grant 0, d_out 0, busy 0, dwell count 0, last NREQ-1.
REQ-026 Reset mid-ownership drops the grant on the next edge; arbitration resumes on the first edge after rst deasserts, with no memory of the previous owner.

Structure
REQ-027 Package led_arb_pkg SHALL hold the state enumeration (IDLE, OWNED) and the default constants for NREQ, W and DWELL.
REQ-028 Sub-module rr_pick SHALL be a combinational round-robin picker: inputs are the request vector, the start index and an exclude mask; outputs are a one-hot winner and a valid flag. It is instantiated once.
REQ-029 Implementation budget: 120-400 lines of RTL in total.

Verification (NREQ=4, W=8, DWELL=4)
REQ-030 After reset, req=0001 and data0=0xA5 -> one cycle later grant=0001, d_out=0xA5, busy=1.
REQ-031 req=0110 starting from IDLE after reset -> grant=0010 for 4 cycles, then 0100 for 4 cycles, then 0010, alternating.
REQ-032 Owner 0 drops req while req2 is high -> next cycle grant=0100, with no idle cycle.
REQ-033 Only req3 held high for 20 cycles -> grant=1000 throughout; dwell saturates; no glitch on d_out.
REQ-034 rst asserted for 1 cycle during ownership of index 2 -> next cycle all outputs 0; with req=1111 afterwards, grant=0001 first.
REQ-035 Random req/data for 10k cycles -> grant one-hot or zero every cycle, and d_out matches the scoreboard model.
